osc_tick_gen: RTL and testbench
===============================

Name: osc_tick_gen

Overview:
Parametrised multi-channel tick/clock-enable generator driven by the fabric RC oscillator clock (nominally 50 MHz). It replaces ad-hoc fabric dividers feeding I2C bit-timing logic.
- Each channel produces a programmable-rate single-cycle TICK strobe and an optional 50%-duty square wave.
- Divisor updates are glitch-free.
- A start-up settle counter holds all channels idle until the oscillator is trusted.

Parameters:
NUM_CH, 4, number of independent tick channels (1..8)
DIV_W, 16, divisor width in bits
DEFAULT_DIV, 125, per-channel divisor after reset (50 MHz / 125 = 400 kHz = 4x 100 kHz SCL)
STARTUP_CYCLES, 1024, CLK cycles after reset release before READY asserts (>=1)

Ports:
CLK  input  1  oscillator-derived fabric clock, single clock domain
RESETN  input  1  asynchronous active-low reset
EN  input  NUM_CH  per-channel run enable, level
MODE  input  NUM_CH  per-channel mode: 0 = tick only, 1 = tick plus square wave on SQ
DIV_VAL  input  NUM_CH*DIV_W  per-channel divisor, channel i at bits [i*DIV_W +: DIV_W]
DIV_LOAD  input  NUM_CH  one-cycle strobe capturing DIV_VAL slice i into shadow i
TICK  output  NUM_CH  registered one-cycle strobe, period = active divisor
SQ  output  NUM_CH  registered square wave, period = 2 x active divisor (MODE=1 only)
PENDING  output  NUM_CH  shadow divisor loaded, not yet active
READY  output  1  start-up settle complete

Behaviour:
- Reset (RESETN low, asynchronous): READY=0, TICK=0, SQ=0, PENDING=0. Startup counter=0. Active and shadow divisors=DEFAULT_DIV. Channel counters=DEFAULT_DIV-1.
- Startup: the counter increments on each CLK edge with RESETN high. READY rises on the edge on which the count reaches STARTUP_CYCLES. READY then stays high until the next reset.
- While READY=0, every channel behaves as if EN=0.
- Divisor rule: an effective divisor of 0 is treated as 1. Counter width is DIV_W.
- Channel idle (EN=0 or READY=0): counter is held at active_div-1; TICK=0; SQ=0.
  - A pending shadow is promoted to active immediately, and PENDING clears on the next edge.
- Channel run (EN=1 and READY=1), each edge:
  - Counter != 0: decrement; TICK=0.
  - Counter == 0 (terminal): TICK=1 for one cycle; SQ toggles if MODE=1; counter reloads to div-1.
  - The divisor used at the reload is the shadow if PENDING, otherwise the active divisor. The shadow becomes active and PENDING clears.
- Timing: the first TICK is registered active_div cycles after the first edge on which EN=1 is sampled.
  - Example: div=4 gives TICK on the 4th, 8th, 12th... edges.
  - div=1 gives TICK high continuously from the first edge.
- DIV_LOAD: captures the slice into the shadow and sets PENDING on the same edge. The active period never changes mid-count, so there are no runt ticks.
  - DIV_LOAD coincident with terminal count: the newly presented DIV_VAL is used for this reload directly (bypass), and PENDING stays 0.
  - Repeated DIV_LOAD before promotion: last value wins.
- MODE change while running: takes effect at the next terminal count. MODE=0 forces SQ=0 on the next edge.
- EN deassert mid-count: counter reloads on the next edge. Re-enabling restarts a full period; no partial tick.
- Channels are fully independent. Simultaneous terminal counts on several channels are allowed.
- Reset mid-operation: all state clears immediately and READY re-runs the full STARTUP_CYCLES.

Decomposition:
- Package osc_tick_pkg holds:
  - DIV_W_DEF and DEFAULT_DIV_DEF;
  - MODE_TICK=0 and MODE_SQ=1 constants;
  - the function eff_div(d), returning d==0 ? 1 : d.
- Sub-module osc_tick_chan: one channel (counter, active/shadow divisor, PENDING, TICK, SQ), instantiated NUM_CH times in a generate loop.
- The top level holds the startup counter, READY and the port slicing.

Test Plan:
1. Reset release, STARTUP_CYCLES=16, EN=all 1 -> READY rises on edge 16. No TICK before READY. Ch0 (div 125) first TICK 125 edges after READY.
2. Ch1 DIV_VAL=4 loaded while idle, EN=1, MODE=1 -> TICK every 4 cycles. SQ period 8, 50% duty. PENDING high for exactly one cycle during the load.
3. Ch2 running div=10; DIV_LOAD=3 at count 6 -> one more 10-cycle period completes, then 3-cycle periods. PENDING clears at that terminal count.
4. DIV_LOAD=5 on the exact terminal-count cycle -> next period is 5 cycles, PENDING never asserts. Repeat with DIV_VAL=0 -> TICK every cycle.
5. EN dropped mid-count at count 2 of div=8, re-raised 3 cycles later -> TICK=0 and SQ=0 throughout. First new TICK exactly 8 edges after re-enable.
6. RESETN pulsed low mid-run on all channels -> all outputs 0 asynchronously, divisors back to 125. READY re-asserts after STARTUP_CYCLES.

Source files
------------

// File: rtl/osc_tick_pkg.sv
// Shared constants and helpers for the oscillator tick generator.
package osc_tick_pkg;

  localparam int DIV_W_DEF       = 16;
  localparam int DEFAULT_DIV_DEF = 125;

  localparam logic MODE_TICK = 1'b0;
  localparam logic MODE_SQ   = 1'b1;

  // A programmed divisor of zero would stall the counter, so it runs as divide-by-one.
  function automatic logic [31:0] eff_div(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/osc_tick_chan.sv
// One tick channel: down counter, active/shadow divisor pair, TICK strobe and SQ wave.
module osc_tick_chan
  import osc_tick_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             mode_i,
  input  logic [DIV_W-1:0] div_val_i,
  input  logic             div_load_i,
  output logic             tick_o,
  output logic             sq_o,
  output logic             pending_o
);

  localparam logic [DIV_W-1:0] DEF_DIV    = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DEF_RELOAD = DIV_W'((DEFAULT_DIV == 0) ? 0 : DEFAULT_DIV - 1);

  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] activeDiv_q, activeDiv_d;
  logic [DIV_W-1:0] shadowDiv_q, shadowDiv_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             terminal;

  // Counter reload value for a divisor, with zero treated as one.
  function automatic logic [DIV_W-1:0] reloadOf(input logic [DIV_W-1:0] d);
    logic [31:0] e;
    e = eff_div(32'(d));
    return DIV_W'(e - 32'd1);
  endfunction

  // Next-state logic: idle parks the counter, run counts down and reloads at terminal count.
  always_comb begin
    count_d     = count_q;
    activeDiv_d = activeDiv_q;
    shadowDiv_d = shadowDiv_q;
    pend_d      = pend_q;
    tick_d      = 1'b0;
    sq_d        = 1'b0;
    terminal    = (count_q == '0);

    if (!run_i) begin
      if (div_load_i) begin
        shadowDiv_d = div_val_i;
        pend_d      = 1'b1;
        count_d     = reloadOf(activeDiv_q);
      end else if (pend_q) begin
        activeDiv_d = shadowDiv_q;
        pend_d      = 1'b0;
        count_d     = reloadOf(shadowDiv_q);
      end else begin
        count_d = reloadOf(activeDiv_q);
      end
    end else if (!terminal) begin
      count_d = count_q - DIV_W'(1);
      sq_d    = (mode_i == MODE_TICK) ? 1'b0 : sq_q;
      if (div_load_i) begin
        shadowDiv_d = div_val_i;
        pend_d      = 1'b1;
      end
    end else begin
      tick_d = 1'b1;
      sq_d   = (mode_i == MODE_SQ) ? ~sq_q : 1'b0;
      if (div_load_i) begin
        activeDiv_d = div_val_i;
        shadowDiv_d = div_val_i;
        pend_d      = 1'b0;
        count_d     = reloadOf(div_val_i);
      end else if (pend_q) begin
        activeDiv_d = shadowDiv_q;
        pend_d      = 1'b0;
        count_d     = reloadOf(shadowDiv_q);
      end else begin
        count_d = reloadOf(activeDiv_q);
      end
    end
  end

  // Channel state registers, cleared to the default divisor on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q     <= DEF_RELOAD;
      activeDiv_q <= DEF_DIV;
      shadowDiv_q <= DEF_DIV;
      pend_q      <= 1'b0;
      tick_q      <= 1'b0;
      sq_q        <= 1'b0;
    end else begin
      count_q     <= count_d;
      activeDiv_q <= activeDiv_d;
      shadowDiv_q <= shadowDiv_d;
      pend_q      <= pend_d;
      tick_q      <= tick_d;
      sq_q        <= sq_d;
    end
  end

  assign tick_o    = tick_q;
  assign sq_o      = sq_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/osc_tick_gen.sv
// Multi-channel tick generator: start-up settle counter plus NUM_CH independent channels.
module osc_tick_gen
  import osc_tick_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DIV_W          = DIV_W_DEF,
  parameter int DEFAULT_DIV    = DEFAULT_DIV_DEF,
  parameter int STARTUP_CYCLES = 1024
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic [NUM_CH-1:0]       EN,
  input  logic [NUM_CH-1:0]       MODE,
  input  logic [NUM_CH*DIV_W-1:0] DIV_VAL,
  input  logic [NUM_CH-1:0]       DIV_LOAD,
  output logic [NUM_CH-1:0]       TICK,
  output logic [NUM_CH-1:0]       SQ,
  output logic [NUM_CH-1:0]       PENDING,
  output logic                    READY
);

  localparam int             SU_W    = $clog2(STARTUP_CYCLES + 1);
  localparam logic [SU_W-1:0] SU_LAST = SU_W'(STARTUP_CYCLES);

  logic [SU_W-1:0] startup_q, startup_d;
  logic            ready_q, ready_d;

  // Settle counter saturates at STARTUP_CYCLES; READY rises on the edge it gets there.
  always_comb begin
    startup_d = startup_q;
    ready_d   = ready_q;
    if (startup_q != SU_LAST) begin
      startup_d = startup_q + SU_W'(1);
      if (startup_d == SU_LAST) begin
        ready_d = 1'b1;
      end
    end
  end

  // Start-up state registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      startup_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      startup_q <= startup_d;
      ready_q   <= ready_d;
    end
  end

  assign READY = ready_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    osc_tick_chan #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .clk_i     (CLK),
      .rst_ni    (RESETN),
      .run_i     (EN[i] & ready_q),
      .mode_i    (MODE[i]),
      .div_val_i (DIV_VAL[i*DIV_W +: DIV_W]),
      .div_load_i(DIV_LOAD[i]),
      .tick_o    (TICK[i]),
      .sq_o      (SQ[i]),
      .pending_o (PENDING[i])
    );
  end

endmodule

// File: tb/tb_osc_tick_gen.sv
// Testbench for osc_tick_gen: directed corner sequences, a vector table and a randomized run
// checked every cycle against a period/elapsed-count reference model.
module tb_osc_tick_gen;

  localparam int NUM_CH         = 4;
  localparam int DIV_W          = 16;
  localparam int DEFAULT_DIV    = 125;
  localparam int STARTUP_CYCLES = 16;
  localparam int WAIT_LIMIT     = 400;

  logic                    CLK;
  logic                    RESETN;
  logic [NUM_CH-1:0]       EN;
  logic [NUM_CH-1:0]       MODE;
  logic [NUM_CH*DIV_W-1:0] DIV_VAL;
  logic [NUM_CH-1:0]       DIV_LOAD;
  logic [NUM_CH-1:0]       TICK;
  logic [NUM_CH-1:0]       SQ;
  logic [NUM_CH-1:0]       PENDING;
  logic                    READY;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state.
  int  mEdges;
  bit  mReady;
  int  mActive[NUM_CH];
  int  mShadow[NUM_CH];
  int  mElapsed[NUM_CH];
  bit  mPend[NUM_CH];
  bit  mTick[NUM_CH];
  bit  mSq[NUM_CH];

  typedef struct {
    int div;
    bit mode;
    int expFirst;
    int expPeriod;
    int expSqHigh;
  } vec_t;

  vec_t vecs[5];

  osc_tick_gen #(
    .NUM_CH        (NUM_CH),
    .DIV_W         (DIV_W),
    .DEFAULT_DIV   (DEFAULT_DIV),
    .STARTUP_CYCLES(STARTUP_CYCLES)
  ) dut (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .EN      (EN),
    .MODE    (MODE),
    .DIV_VAL (DIV_VAL),
    .DIV_LOAD(DIV_LOAD),
    .TICK    (TICK),
    .SQ      (SQ),
    .PENDING (PENDING),
    .READY   (READY)
  );

  // Free-running 100 MHz bench clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Compare one observed value with its expectation and tally the result.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic waitEdge();
    @(posedge CLK);
    #1;
  endtask

  // Pulse DIV_LOAD on one channel with the given divisor for a single edge.
  task automatic applyStimulus(input int ch, input int div);
    DIV_VAL[ch*DIV_W +: DIV_W] = DIV_W'(div);
    DIV_LOAD[ch] = 1'b1;
    waitEdge();
    DIV_LOAD[ch] = 1'b0;
  endtask

  // Count edges until TICK on a channel; an expired bound returns WAIT_LIMIT.
  task automatic waitTick(input int ch, output int edges);
    edges = 0;
    do begin
      waitEdge();
      edges++;
    end while (TICK[ch] !== 1'b1 && edges < WAIT_LIMIT);
  endtask

  // Count edges until READY; an expired bound returns WAIT_LIMIT.
  task automatic waitReady(output int edges, output bit sawTick);
    edges   = 0;
    sawTick = 1'b0;
    do begin
      waitEdge();
      edges++;
      if (TICK !== '0 && READY !== 1'b1) sawTick = 1'b1;
    end while (READY !== 1'b1 && edges < WAIT_LIMIT);
  endtask

  // Reference model: each channel tracks edges elapsed in its current period.
  initial begin
    forever begin
      @(posedge CLK or negedge RESETN);
      if (!RESETN) begin
        mEdges = 0;
        mReady = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
          mActive[c]  = DEFAULT_DIV;
          mShadow[c]  = DEFAULT_DIV;
          mElapsed[c] = 0;
          mPend[c]    = 1'b0;
          mTick[c]    = 1'b0;
          mSq[c]      = 1'b0;
        end
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          int val;
          int period;
          val    = int'(DIV_VAL[c*DIV_W +: DIV_W]);
          period = (mActive[c] == 0) ? 1 : mActive[c];
          if (!(EN[c] && mReady)) begin
            mTick[c]    = 1'b0;
            mSq[c]      = 1'b0;
            mElapsed[c] = 0;
            if (DIV_LOAD[c]) begin
              mShadow[c] = val;
              mPend[c]   = 1'b1;
            end else if (mPend[c]) begin
              mActive[c] = mShadow[c];
              mPend[c]   = 1'b0;
            end
          end else begin
            mElapsed[c]++;
            if (mElapsed[c] >= period) begin
              mTick[c]    = 1'b1;
              mSq[c]      = MODE[c] ? !mSq[c] : 1'b0;
              mElapsed[c] = 0;
              if (DIV_LOAD[c]) begin
                mActive[c] = val;
                mPend[c]   = 1'b0;
              end else if (mPend[c]) begin
                mActive[c] = mShadow[c];
                mPend[c]   = 1'b0;
              end
            end else begin
              mTick[c] = 1'b0;
              mSq[c]   = MODE[c] ? mSq[c] : 1'b0;
              if (DIV_LOAD[c]) begin
                mShadow[c] = val;
                mPend[c]   = 1'b1;
              end
            end
          end
        end
        if (mEdges < STARTUP_CYCLES) mEdges++;
        mReady = (mEdges >= STARTUP_CYCLES);
      end
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      logic [NUM_CH-1:0] expTick;
      logic [NUM_CH-1:0] expSq;
      logic [NUM_CH-1:0] expPend;
      @(posedge CLK);
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
        expTick[c] = mTick[c];
        expSq[c]   = mSq[c];
        expPend[c] = mPend[c];
      end
      checkOutput("model READY", 32'(READY), 32'(mReady));
      checkOutput("model TICK", 32'(TICK), 32'(expTick));
      checkOutput("model SQ", 32'(SQ), 32'(expSq));
      checkOutput("model PENDING", 32'(PENDING), 32'(expPend));
    end
  end

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int n;
    int m;
    int sqHigh;
    bit sawTick;
    bit noisy;

    vecs[0] = '{4, 1'b1, 4, 4, 8};
    vecs[1] = '{1, 1'b0, 1, 1, 0};
    vecs[2] = '{0, 1'b1, 1, 1, 2};
    vecs[3] = '{7, 1'b1, 7, 7, 14};
    vecs[4] = '{3, 1'b0, 3, 3, 0};

    EN       = '0;
    MODE     = '0;
    DIV_LOAD = '0;
    DIV_VAL  = '0;
    RESETN   = 1'b1;
    #2 RESETN = 1'b0;
    repeat (3) waitEdge();
    checkOutput("reset READY", 32'(READY), 32'd0);
    checkOutput("reset TICK", 32'(TICK), 32'd0);
    checkOutput("reset PENDING", 32'(PENDING), 32'd0);

    // Startup settle and default divisor.
    EN = '1;
    #2 RESETN = 1'b1;
    waitReady(n, sawTick);
    checkOutput("startup edges", n, STARTUP_CYCLES);
    checkOutput("tick before ready", 32'(sawTick), 32'd0);
    waitTick(0, n);
    checkOutput("ch0 first tick", n, DEFAULT_DIV);

    // Vector table on channel 1: load while idle, then run.
    for (int i = 0; i < 5; i++) begin
      EN[1]   = 1'b0;
      MODE[1] = vecs[i].mode;
      waitEdge();
      applyStimulus(1, vecs[i].div);
      checkOutput("table pending set", 32'(PENDING[1]), 32'd1);
      waitEdge();
      checkOutput("table pending clear", 32'(PENDING[1]), 32'd0);
      EN[1] = 1'b1;
      waitTick(1, n);
      checkOutput("table first tick", n, vecs[i].expFirst);
      waitTick(1, n);
      checkOutput("table period", n, vecs[i].expPeriod);
      sqHigh = 0;
      for (int k = 0; k < 4 * vecs[i].expPeriod; k++) begin
        waitEdge();
        if (SQ[1] === 1'b1) sqHigh++;
      end
      checkOutput("table sq high", sqHigh, vecs[i].expSqHigh);
    end

    // Channel 2: shadow load mid-count completes the old period first.
    EN[2] = 1'b0;
    waitEdge();
    applyStimulus(2, 10);
    waitEdge();
    EN[2] = 1'b1;
    waitTick(2, n);
    checkOutput("ch2 div10 first", n, 10);
    repeat (3) waitEdge();
    applyStimulus(2, 3);
    checkOutput("ch2 pending mid", 32'(PENDING[2]), 32'd1);
    waitTick(2, m);
    checkOutput("ch2 old period", 4 + m, 10);
    checkOutput("ch2 pending cleared", 32'(PENDING[2]), 32'd0);
    waitTick(2, n);
    checkOutput("ch2 new period a", n, 3);
    waitTick(2, n);
    checkOutput("ch2 new period b", n, 3);

    // Load coincident with terminal count bypasses the shadow.
    repeat (2) waitEdge();
    applyStimulus(2, 5);
    checkOutput("bypass tick", 32'(TICK[2]), 32'd1);
    checkOutput("bypass no pending", 32'(PENDING[2]), 32'd0);
    waitTick(2, n);
    checkOutput("bypass period 5", n, 5);
    repeat (4) waitEdge();
    applyStimulus(2, 0);
    checkOutput("bypass0 tick", 32'(TICK[2]), 32'd1);
    checkOutput("bypass0 no pending", 32'(PENDING[2]), 32'd0);
    waitTick(2, n);
    checkOutput("div0 period a", n, 1);
    waitTick(2, n);
    checkOutput("div0 period b", n, 1);

    // Channel 3: enable dropped mid-count, then a full period on re-enable.
    EN[3]   = 1'b0;
    MODE[3] = 1'b1;
    waitEdge();
    applyStimulus(3, 8);
    waitEdge();
    EN[3] = 1'b1;
    waitTick(3, n);
    checkOutput("ch3 div8 first", n, 8);
    checkOutput("ch3 sq after tick", 32'(SQ[3]), 32'd1);
    repeat (5) waitEdge();
    EN[3] = 1'b0;
    noisy = 1'b0;
    repeat (3) begin
      waitEdge();
      if (TICK[3] !== 1'b0 || SQ[3] !== 1'b0) noisy = 1'b1;
    end
    checkOutput("ch3 quiet while disabled", 32'(noisy), 32'd0);
    EN[3] = 1'b1;
    waitTick(3, n);
    checkOutput("ch3 restart period", n, 8);

    // Asynchronous reset mid-run.
    applyStimulus(0, 9);
    checkOutput("ch2 ticking pre reset", 32'(TICK[2]), 32'd1);
    #2 RESETN = 1'b0;
    #1;
    checkOutput("async TICK", 32'(TICK), 32'd0);
    checkOutput("async SQ", 32'(SQ), 32'd0);
    checkOutput("async PENDING", 32'(PENDING), 32'd0);
    checkOutput("async READY", 32'(READY), 32'd0);
    repeat (2) waitEdge();
    EN = '1;
    #2 RESETN = 1'b1;
    waitReady(n, sawTick);
    checkOutput("restart edges", n, STARTUP_CYCLES);
    checkOutput("restart tick before ready", 32'(sawTick), 32'd0);
    waitTick(0, n);
    checkOutput("restart ch0 default div", n, DEFAULT_DIV);

    // Randomized traffic, checked by the per-cycle model comparison.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        EN[c]       = ($urandom_range(0, 15) != 0);
        if ($urandom_range(0, 31) == 0) MODE[c] = 1'($urandom_range(0, 1));
        DIV_LOAD[c] = ($urandom_range(0, 9) == 0);
        DIV_VAL[c*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 12));
      end
      waitEdge();
    end
    DIV_LOAD = '0;
    EN       = '0;
    repeat (2) waitEdge();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
